ahb_arbiter_rr: RTL and testbench

- Parametrised AHB bus arbiter, next generation of the single-mode priority arbiter.
- Sits between the AHB masters (DMA, CPU, refresh/test engines) and the shared SDRAM-controller slave port.
- Selects fixed-priority or round-robin arbitration and parks the bus on a default master.
- Honours locked transfers, enforces a maximum tenure per grant, and tracks the AHB address-phase owner (hmaster/hmastlock) against hready.

---
 rtl/ahb_arbiter_rr.sv | 120 ++++++++++++
 tb/tb_ahb_arbiter_rr.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_rr.sv
// AHB bus arbiter with fixed-priority or round-robin selection, default-master parking,
// locked-transfer support, per-tenure beat limit and address-phase owner tracking.
module ahb_arbiter_rr #(
  parameter int NUM_MASTERS    = 4,
  parameter int MODE           = 0,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16,
  localparam int MW            = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock,
  output logic                   grant_change
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  typedef enum logic [1:0] {PARK = 2'd0, OWN = 2'd1, LOCK = 2'd2} state_t;

  state_t                  state_r, next_state_s;
  logic [NUM_MASTERS-1:0]  grant_r, next_grant_s, cand_s;
  logic [MW-1:0]           master_r, owner_s, win_s, ptr_r, idx_s;
  logic [HW-1:0]           hold_r;
  logic                    mastlock_r, change_r;
  logic                    own_req_s, own_lock_s, active_s, others_s;
  logic                    limit_s, trigger_s, found_s, differs_s;

  // Owner index decoded from the one-hot grant register
  always_comb begin
    owner_s = DEF_IDX;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      owner_s = grant_r[i] ? MW'(i) : owner_s;
    end
  end

  assign own_req_s  = hbusreq[owner_s];
  assign own_lock_s = own_req_s & hlock[owner_s];
  assign active_s   = hready & ((htrans == 2'b10) | (htrans == 2'b11));
  assign others_s   = |(hbusreq & ~grant_r);
  // A held lock suppresses the tenure limit in the same cycle it would expire
  assign limit_s    = (MAX_HOLD != 0) && (hold_r == HOLD_MAX) && others_s && !own_lock_s;
  assign trigger_s  = (state_r == PARK) | ~own_req_s | limit_s;

  // Winner selection and next grant/state
  always_comb begin
    cand_s       = limit_s ? (hbusreq & ~grant_r) : hbusreq;
    found_s      = 1'b0;
    win_s        = DEF_IDX;
    idx_s        = DEF_IDX;
    next_state_s = state_r;
    next_grant_s = '0;
    if (MODE == 0) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        win_s   = cand_s[i] ? MW'(i) : win_s;
        found_s = found_s | cand_s[i];
      end
    end else begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        idx_s   = MW'((int'(ptr_r) + k) % NUM_MASTERS);
        win_s   = (cand_s[idx_s] && !found_s) ? idx_s : win_s;
        found_s = found_s | cand_s[idx_s];
      end
    end
    next_grant_s[win_s] = 1'b1;
    if (!trigger_s) begin
      next_grant_s = grant_r;
      next_state_s = own_lock_s ? LOCK : OWN;
    end else if (!found_s) begin
      next_state_s = PARK;
    end else begin
      next_state_s = (hbusreq[win_s] & hlock[win_s]) ? LOCK : OWN;
    end
  end

  assign differs_s = (next_grant_s != grant_r);

  // Arbiter state; everything freezes while hready is low
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r    <= PARK;
      grant_r    <= DEF_GRANT;
      master_r   <= DEF_IDX;
      mastlock_r <= 1'b0;
      change_r   <= 1'b0;
      hold_r     <= '0;
      ptr_r      <= DEF_IDX;
    end else if (hready) begin
      state_r    <= next_state_s;
      grant_r    <= next_grant_s;
      master_r   <= owner_s;
      mastlock_r <= own_lock_s;
      change_r   <= differs_s;
      if (differs_s) begin
        hold_r <= '0;
        ptr_r  <= win_s;
      end else if (active_s && (hold_r != HOLD_MAX)) begin
        hold_r <= hold_r + HW'(1);
      end else begin
        hold_r <= hold_r;
      end
    end else begin
      change_r <= 1'b0;
    end
  end

  assign hgrant       = grant_r;
  assign hmaster      = master_r;
  assign hmastlock    = mastlock_r;
  assign grant_change = change_r;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Directed bench for ahb_arbiter_rr: one fixed-priority and one round-robin instance
// share the stimulus; each phase checks the instance it targets.
module tb_ahb_arbiter_rr;

  localparam int N = 4;

  logic         hclk = 1'b0;
  logic         hreset;
  logic         hready;
  logic [N-1:0] hbusreq;
  logic [N-1:0] hlock;
  logic [1:0]   htrans;

  logic [N-1:0] grant_a, grant_b;
  logic [1:0]   master_a, master_b;
  logic         lock_a, lock_b, chg_a, chg_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 hclk = ~hclk;

  ahb_arbiter_rr #(.NUM_MASTERS(N), .MODE(0), .DEFAULT_MASTER(2), .MAX_HOLD(4)) dut_a (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hready(hready), .hgrant(grant_a), .hmaster(master_a), .hmastlock(lock_a),
    .grant_change(chg_a)
  );

  ahb_arbiter_rr #(.NUM_MASTERS(N), .MODE(1), .DEFAULT_MASTER(0), .MAX_HOLD(4)) dut_b (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock), .htrans(htrans),
    .hready(hready), .hgrant(grant_b), .hmaster(master_b), .hmastlock(lock_b),
    .grant_change(chg_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hreset  = 1'b1;
    hready  = 1'b1;
    hbusreq = 4'b0000;
    hlock   = 4'b0000;
    htrans  = 2'b00;
    tick();
    tick();
    hreset = 1'b0;

    // reset values
    check_val("rst_grant_a", grant_a, 32'h4);
    check_val("rst_master_a", master_a, 32'd2);
    check_val("rst_lock_a", lock_a, 32'd0);
    check_val("rst_chg_a", chg_a, 32'd0);
    check_val("rst_grant_b", grant_b, 32'h1);
    check_val("rst_master_b", master_b, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("idle_grant_a", grant_a, 32'h4);
      check_val("idle_master_a", master_a, 32'd2);
      check_val("idle_chg_a", chg_a, 32'd0);
    end

    // fixed priority: move to master 0, then 0 drops with 1 and 2 requesting
    hbusreq = 4'b0001;
    tick();
    check_val("fp_grant0", grant_a, 32'h1);
    check_val("fp_chg0", chg_a, 32'd1);
    check_val("fp_master_trail", master_a, 32'd2);
    hbusreq = 4'b0110;
    tick();
    check_val("fp_grant2", grant_a, 32'h4);
    check_val("fp_chg2", chg_a, 32'd1);
    check_val("fp_master0", master_a, 32'd0);
    tick();
    check_val("fp_master2", master_a, 32'd2);
    check_val("fp_chg_off", chg_a, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("fp_hold2", grant_a, 32'h4);
    end

    // locked tenure of master 1 with master 3 waiting, limit expiring under lock
    hbusreq = 4'b0010;
    hlock   = 4'b0010;
    htrans  = 2'b10;
    tick();
    check_val("lk_grant1", grant_a, 32'h2);
    check_val("lk_chg1", chg_a, 32'd1);
    check_val("lk_mlock0", lock_a, 32'd0);
    hbusreq = 4'b1010;
    htrans  = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("lk_grant", grant_a, 32'h2);
      check_val("lk_mlock", lock_a, 32'd1);
      check_val("lk_chg", chg_a, 32'd0);
    end
    hlock = 4'b0000;
    tick();
    check_val("lk_release_grant", grant_a, 32'h8);
    check_val("lk_release_chg", chg_a, 32'd1);
    check_val("lk_release_mlock", lock_a, 32'd0);
    check_val("lk_release_master", master_a, 32'd1);

    // wait-state freeze with owner 3 dropping its request
    htrans = 2'b00;
    tick();
    check_val("st_master3", master_a, 32'd3);
    check_val("st_grant3", grant_a, 32'h8);
    hready  = 1'b0;
    hbusreq = 4'b0010;
    htrans  = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("st_frz_grant", grant_a, 32'h8);
      check_val("st_frz_master", master_a, 32'd3);
      check_val("st_frz_chg", chg_a, 32'd0);
    end
    hready = 1'b1;
    tick();
    check_val("st_rearb_grant", grant_a, 32'h2);
    check_val("st_rearb_chg", chg_a, 32'd1);
    check_val("st_rearb_master", master_a, 32'd3);
    tick();
    check_val("st_pulse_end", chg_a, 32'd0);
    check_val("st_master1", master_a, 32'd1);

    // round robin with limit 4: rotation starts at pointer+1 = 1
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    check_val("rr_rst_grant_b", grant_b, 32'h1);
    check_val("rr_rst_grant_a", grant_a, 32'h4);
    hbusreq = 4'b1111;
    hlock   = 4'b0000;
    htrans  = 2'b10;
    for (int e = 0; e < 32; e++) begin
      tick();
      check_val("rr_grant", grant_b, 32'd1 << ((1 + e / 5) % 4));
      check_val("rr_chg", chg_b, (e % 5 == 0) ? 32'd1 : 32'd0);
    end

    // reset while master 3 owns mid-tenure
    check_val("rr_owner3", grant_b, 32'h8);
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    check_val("mr_grant", grant_b, 32'h1);
    check_val("mr_master", master_b, 32'd0);
    check_val("mr_chg", chg_b, 32'd0);
    check_val("mr_mlock", lock_b, 32'd0);
    tick();
    check_val("mr_ptr_grant", grant_b, 32'h2);
    check_val("mr_ptr_chg", chg_b, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("mr_cnt_hold", grant_b, 32'h2);
    end
    tick();
    check_val("mr_cnt_next", grant_b, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
